// File: rtl/sprite_linebuf_if.sv
// Renderer and composer side signals of the sprite line buffer.
interface sprite_linebuf_if #(
    parameter int IDX_W  = 10,
    parameter int DATA_W = 16
);
    logic              line_render_start;
    logic [IDX_W-1:0]  linebuf_rdidx;
    logic [DATA_W-1:0] linebuf_rddata;
    logic [IDX_W-1:0]  linebuf_wridx;
    logic [DATA_W-1:0] linebuf_wrdata;
    logic              linebuf_wren;
    logic              disp_rden;
    logic [IDX_W-1:0]  disp_idx;
    logic [DATA_W-1:0] disp_data;
    logic              init_busy;
    logic              clear_overrun;

    // Line buffer side
    modport slave (
        input  line_render_start,
        input  linebuf_rdidx,
        output linebuf_rddata,
        input  linebuf_wridx,
        input  linebuf_wrdata,
        input  linebuf_wren,
        input  disp_rden,
        input  disp_idx,
        output disp_data,
        output init_busy,
        output clear_overrun
    );

    // Renderer / composer side
    modport master (
        output line_render_start,
        output linebuf_rdidx,
        input  linebuf_rddata,
        output linebuf_wridx,
        output linebuf_wrdata,
        output linebuf_wren,
        output disp_rden,
        output disp_idx,
        input  disp_data,
        input  init_busy,
        input  clear_overrun
    );
endinterface

// File: rtl/sprite_linebuf.sv
// Double-buffered sprite line buffer: render bank for read-modify-write by
// the renderer, display bank read-and-cleared by the composer, plus a
// background sweep that zeroes the off-screen tail of the display bank.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_INIT  | post-reset clear of both banks, one entry per cycle
// ST_IDLE  | normal operation, nothing left to sweep
// ST_SWEEP | zeroing entries DISP_WIDTH..DEPTH-1 of the display bank
module sprite_linebuf #(
    parameter int DEPTH      = 1024,
    parameter int DISP_WIDTH = 640
) (
    input logic             clk,
    input logic             rst,
    sprite_linebuf_if.slave bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int DATA_W = 16;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] SWEEP_START = IDX_W'(DISP_WIDTH);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               render_bank_q;
    logic [DATA_W-1:0]  rddata_q, rddata_d;
    logic [DATA_W-1:0]  disp_data_q, disp_data_d;
    logic               overrun_q, overrun_d;

    logic [DATA_W-1:0]  bank0_q [DEPTH];
    logic [DATA_W-1:0]  bank1_q [DEPTH];

    logic               in_init;
    logic               in_sweep;
    logic [DATA_W-1:0]  render_rd_raw;
    logic [DATA_W-1:0]  disp_rd_raw;

    assign in_init  = (state_q == ST_INIT);
    assign in_sweep = (state_q == ST_SWEEP);

    // Bank selection uses the mapping in force during the current cycle;
    // a swap only takes effect after the edge.
    assign render_rd_raw = render_bank_q ? bank1_q[bus.linebuf_rdidx] : bank0_q[bus.linebuf_rdidx];
    assign disp_rd_raw   = render_bank_q ? bank0_q[bus.disp_idx]      : bank1_q[bus.disp_idx];

    // Next-state, sweep counter and overrun detection
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        overrun_d = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.line_render_start) begin
                    state_d   = ST_SWEEP;
                    clr_cnt_d = SWEEP_START;
                end
            end
            ST_SWEEP: begin
                if (bus.line_render_start) begin
                    // Previous bank's tail is abandoned; restart on the new one.
                    overrun_d = 1'b1;
                    clr_cnt_d = SWEEP_START;
                end else if (clr_cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_INIT;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Read data for both ports; everything reads as zero during the init clear
    always_comb begin
        rddata_d    = '0;
        disp_data_d = '0;
        if (!in_init) begin
            if (bus.linebuf_wren && (bus.linebuf_wridx == bus.linebuf_rdidx)) begin
                rddata_d = bus.linebuf_wrdata;
            end else begin
                rddata_d = render_rd_raw;
            end
            if (bus.disp_rden) begin
                disp_data_d = disp_rd_raw;
            end
        end
    end

    // State, bank mapping and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_INIT;
            clr_cnt_q     <= '0;
            render_bank_q <= 1'b0;
            rddata_q      <= '0;
            disp_data_q   <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rddata_q    <= rddata_d;
            disp_data_q <= disp_data_d;
            overrun_q   <= overrun_d;
            if (bus.line_render_start) begin
                render_bank_q <= ~render_bank_q;
            end
        end
    end

    // Bank storage: init clear, renderer writes, composer read-clear and sweep.
    // The display-side writers all store zero, so overlapping them is harmless.
    always_ff @(posedge clk) begin
        if (in_init) begin
            bank0_q[clr_cnt_q] <= '0;
            bank1_q[clr_cnt_q] <= '0;
        end else begin
            if (bus.linebuf_wren) begin
                if (render_bank_q) begin
                    bank1_q[bus.linebuf_wridx] <= bus.linebuf_wrdata;
                end else begin
                    bank0_q[bus.linebuf_wridx] <= bus.linebuf_wrdata;
                end
            end
            if (bus.disp_rden) begin
                if (render_bank_q) begin
                    bank0_q[bus.disp_idx] <= '0;
                end else begin
                    bank1_q[bus.disp_idx] <= '0;
                end
            end
            if (in_sweep) begin
                if (render_bank_q) begin
                    bank0_q[clr_cnt_q] <= '0;
                end else begin
                    bank1_q[clr_cnt_q] <= '0;
                end
            end
        end
    end

    assign bus.linebuf_rddata = rddata_q;
    assign bus.disp_data      = disp_data_q;
    assign bus.init_busy      = in_init;
    assign bus.clear_overrun  = overrun_q;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Bench for sprite_linebuf: directed steps plus a randomized phase, every
// cycle checked against a behavioural model of the two banks.
module tb_sprite_linebuf;
    localparam int DEPTH = 1024;
    localparam int DISPW = 640;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_linebuf_if lb ();

    sprite_linebuf #(.DEPTH(DEPTH), .DISP_WIDTH(DISPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (lb.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: bank contents, which bank the renderer owns,
    // remaining init cycles and the position of any tail sweep in progress.
    logic [15:0] mem [2][DEPTH];
    bit          m_rb;
    int          m_init_left;
    bit          m_sw_act;
    int          m_sw_k;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit start, input int rdidx, input int wridx, input int wrdata,
                          input bit wren, input bit rden, input int didx);
        lb.line_render_start = start;
        lb.linebuf_rdidx     = 10'(rdidx);
        lb.linebuf_wridx     = 10'(wridx);
        lb.linebuf_wrdata    = 16'(wrdata);
        lb.linebuf_wren      = wren;
        lb.disp_rden         = rden;
        lb.disp_idx          = 10'(didx);
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: predict from pre-edge model state and inputs, advance the
    // model, then compare the outputs 1 time unit after the edge.
    task automatic cycle();
        logic [15:0] e_rd;
        logic [15:0] e_disp;
        bit          e_ovr;
        bit          in_init;
        in_init = (m_init_left > 0);
        e_rd    = '0;
        e_disp  = '0;
        e_ovr   = 1'b0;
        if (!in_init) begin
            if (lb.linebuf_wren && lb.linebuf_wridx == lb.linebuf_rdidx)
                e_rd = lb.linebuf_wrdata;
            else
                e_rd = mem[m_rb][lb.linebuf_rdidx];
            if (lb.disp_rden)
                e_disp = mem[~m_rb][lb.disp_idx];
            e_ovr = lb.line_render_start && m_sw_act;
        end
        @(posedge clk);
        #1;
        if (!in_init) begin
            if (lb.linebuf_wren) mem[m_rb][lb.linebuf_wridx] = lb.linebuf_wrdata;
            if (lb.disp_rden)    mem[~m_rb][lb.disp_idx] = '0;
            if (m_sw_act) begin
                mem[~m_rb][m_sw_k] = '0;
                if (m_sw_k == DEPTH - 1) m_sw_act = 0;
                else m_sw_k++;
            end
            if (lb.line_render_start) begin
                m_sw_act = 1;
                m_sw_k   = DISPW;
            end
        end
        if (lb.line_render_start) m_rb = ~m_rb;
        if (in_init) m_init_left--;
        check("rddata", lb.linebuf_rddata, e_rd);
        check("disp_data", lb.disp_data, e_disp);
        check("init_busy", {15'b0, lb.init_busy}, {15'b0, m_init_left > 0});
        check("clear_overrun", {15'b0, lb.clear_overrun}, {15'b0, e_ovr});
    endtask

    task automatic run_idle(input int n);
        idle_in();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) mem[b][i] = '0;
        m_rb        = 0;
        m_init_left = DEPTH;
        m_sw_act    = 0;
        m_sw_k      = 0;
        check("rst_rddata", lb.linebuf_rddata, 16'h0000);
        check("rst_disp_data", lb.disp_data, 16'h0000);
        check("rst_init_busy", {15'b0, lb.init_busy}, 16'h0001);
        check("rst_overrun", {15'b0, lb.clear_overrun}, 16'h0000);
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_in();
        #2;
        do_reset();

        // Init clear with garbage traffic and two swaps, all of which must
        // leave the banks cleared.
        for (int i = 0; i < DEPTH; i++) begin
            set_in((i == 100) || (i == 500), $urandom_range(0, 1023), $urandom_range(0, 1023),
                   $urandom_range(0, 65535), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 1023));
            cycle();
        end
        run_idle(2);

        // Both banks read zero at the boundary indices.
        set_in(0, 0, 0, 0, 0, 1, 0);          cycle();
        set_in(0, 639, 0, 0, 0, 1, 639);      cycle();
        set_in(0, 640, 0, 0, 0, 1, 640);      cycle();
        set_in(0, 1023, 0, 0, 0, 1, 1023);    cycle();
        run_idle(1);

        // Write then read, and same-cycle write-first forwarding.
        set_in(0, 0, 100, 16'h1305, 1, 0, 0); cycle();
        set_in(0, 100, 0, 0, 0, 0, 0);        cycle();
        set_in(0, 101, 101, 16'hA0FF, 1, 0, 0); cycle();
        run_idle(1);

        // Render two entries, swap, composer read-clear and tail sweep.
        set_in(0, 0, 5, 16'h0342, 1, 0, 0);   cycle();
        set_in(0, 0, 700, 16'h0311, 1, 0, 0); cycle();
        set_in(1, 0, 0, 0, 0, 0, 0);          cycle();
        set_in(0, 0, 0, 0, 0, 1, 5);          cycle();
        set_in(0, 0, 0, 0, 0, 1, 5);          cycle();
        run_idle(390);
        set_in(0, 0, 0, 0, 0, 1, 700);        cycle();

        // Overrun: second swap 200 cycles in, third after a full sweep.
        set_in(0, 0, 900, 16'h7777, 1, 0, 0); cycle();
        set_in(1, 0, 0, 0, 0, 0, 0);          cycle();
        run_idle(200);
        set_in(1, 0, 0, 0, 0, 0, 0);          cycle();
        run_idle(400);
        set_in(1, 0, 0, 0, 0, 0, 0);          cycle();
        run_idle(5);

        // Write on the swap cycle lands in the bank being released.
        set_in(1, 0, 5, 16'h0001, 1, 0, 0);   cycle();
        set_in(0, 0, 0, 0, 0, 1, 5);          cycle();
        run_idle(2);

        // Randomized traffic with occasional swaps.
        for (int i = 0; i < 3000; i++) begin
            int wi, ri, di;
            bit st;
            wi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023);
            ri = ($urandom_range(0, 3) == 0) ? wi : $urandom_range(0, 1023);
            di = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023);
            st = ($urandom_range(0, 249) == 0) && !(m_sw_act && m_sw_k == DEPTH - 1);
            set_in(st, ri, wi, $urandom_range(0, 65535), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), di);
            cycle();
        end

        // Reset in the middle of a sweep, then sweep every entry of both banks.
        run_idle(400);
        set_in(0, 0, 800, 16'hBEEF, 1, 0, 0); cycle();
        set_in(0, 0, 3, 16'h1234, 1, 0, 0);   cycle();
        set_in(1, 0, 0, 0, 0, 0, 0);          cycle();
        set_in(0, 0, 8, 16'h5555, 1, 0, 0);   cycle();
        run_idle(50);
        do_reset();
        run_idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            set_in(0, i, 0, 0, 0, 1, i);
            cycle();
        end
        run_idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
